// File: rtl/scan_seq_pkg.sv
// Shared state encoding for the scan index sequencer and its helpers.
package scan_seq_pkg;
  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_ACTIVE = 2'd1;
  localparam logic [ST_W-1:0] ST_BLANK  = 2'd2;
endpackage

// File: rtl/scan_dwell_counter.sv
// Loadable dwell down-counter; a zero load value is promoted to 1 so every index lasts at least one cycle.
module scan_dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               dec_i,
  input  logic [DWELL_W-1:0] load_val_i,
  output logic               tc_o
);
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (load_val_i == '0) ? DWELL_W'(1) : load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count marks the last cycle of the current dwell.
  assign tc_o = (cnt_q == DWELL_W'(1));
endmodule

// File: rtl/scan_index_sequencer.sv
// Index/enable sequencer feeding an n-to-2^n decoder; continuous or one-shot scan.
// Define SCAN_BLANK_EN to insert one en=0 cycle between indices (not after the final one-shot index).
module scan_index_sequencer
  import scan_seq_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               one_shot,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [N-1:0]       last_idx,
  output logic [N-1:0]       w,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);
  logic [ST_W-1:0]    state_q, state_d;
  logic [N-1:0]       w_q, w_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic               one_shot_q, one_shot_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [N-1:0]       last_q, last_d;
  logic               cnt_load, cnt_dec, cnt_tc;
  logic [DWELL_W-1:0] cnt_val;

  // On the accepting edge the captured copy is not yet valid, so load straight from the port.
  assign cnt_val = (state_q == ST_IDLE) ? dwell : dwell_q;

  scan_dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (cnt_val),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    en_d       = en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wrap_d     = 1'b0;
    one_shot_d = one_shot_q;
    dwell_d    = dwell_q;
    last_d     = last_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      w_d     = '0;
      en_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_ACTIVE;
            w_d        = '0;
            en_d       = 1'b1;
            busy_d     = 1'b1;
            one_shot_d = one_shot;
            dwell_d    = dwell;
            last_d     = last_idx;
            cnt_load   = 1'b1;
          end
        end
        ST_ACTIVE: begin
          cnt_dec = 1'b1;
          if (cnt_tc) begin
            if (w_q == last_q && one_shot_q) begin
              state_d = ST_IDLE;
              w_d     = '0;
              en_d    = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
`ifdef SCAN_BLANK_EN
              state_d = ST_BLANK;
              en_d    = 1'b0;
`else
              cnt_load = 1'b1;
              if (w_q == last_q) begin
                w_d    = '0;
                wrap_d = 1'b1;
              end else begin
                w_d = w_q + 1'b1;
              end
`endif
            end
          end
        end
`ifdef SCAN_BLANK_EN
        ST_BLANK: begin
          state_d  = ST_ACTIVE;
          en_d     = 1'b1;
          cnt_load = 1'b1;
          if (w_q == last_q) begin
            w_d    = '0;
            wrap_d = 1'b1;
          end else begin
            w_d = w_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          w_d     = '0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      w_q        <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      one_shot_q <= 1'b0;
      dwell_q    <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
      one_shot_q <= one_shot_d;
      dwell_q    <= dwell_d;
      last_q     <= last_d;
    end
  end

  assign w    = w_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_scan_index_sequencer.sv
// Randomized bench for scan_index_sequencer; expected outputs derived arithmetically from scan position.
module tb_scan_index_sequencer;
  localparam int N  = 3;
  localparam int DW = 8;
`ifdef SCAN_BLANK_EN
  localparam int BLK = 1;
`else
  localparam int BLK = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          one_shot = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic [N-1:0]  last_idx = '0;
  logic [N-1:0]  w;
  logic          en, busy, done, wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: scan position k counts cycles since the first cycle of the scan.
  bit m_active = 0;
  bit m_done   = 0;
  bit m_os     = 0;
  int m_d      = 1;
  int m_last   = 0;
  int m_k      = 0;
  int n_scans  = 0;

  scan_index_sequencer #(.N(N), .DWELL_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .one_shot (one_shot),
    .dwell    (dwell),
    .last_idx (last_idx),
    .w        (w),
    .en       (en),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int slot_len();
    return m_d + BLK;
  endfunction

  function automatic int pos_in_period();
    return m_k % ((m_last + 1) * slot_len());
  endfunction

  function automatic int exp_idx();
    return m_active ? pos_in_period() / slot_len() : 0;
  endfunction

  task automatic model_edge(input bit s, input bit p, input bit os, input int d, input int l);
    if (p) begin
      m_active = 0;
      m_done   = 0;
    end else if (!m_active) begin
      m_done = 0;
      if (s) begin
        m_active = 1;
        m_k      = 0;
        m_os     = os;
        m_d      = (d == 0) ? 1 : d;
        m_last   = l;
        n_scans++;
        $display("scan %0d start: one_shot=%0d dwell=%0d last_idx=%0d", n_scans, os, d, l);
      end
    end else begin
      m_k++;
      m_done = 0;
      if (m_os && m_k == (m_last + 1) * slot_len() - BLK) begin
        m_active = 0;
        m_done   = 1;
        $display("scan %0d one-shot pass complete", n_scans);
      end
    end
  endtask

  task automatic check_outputs();
    int r;
    if (m_active) begin
      r = pos_in_period();
      check("w", 32'(w), 32'(r / slot_len()));
      check("en", 32'(en), 32'((r % slot_len()) != m_d));
      check("busy", 32'(busy), 32'd1);
      check("done", 32'(done), 32'd0);
      check("wrap", 32'(wrap), 32'(!m_os && m_k > 0 && r == 0));
    end else begin
      check("w", 32'(w), 32'd0);
      check("en", 32'(en), 32'd0);
      check("busy", 32'(busy), 32'd0);
      check("done", 32'(done), 32'(m_done));
      check("wrap", 32'(wrap), 32'd0);
    end
  endtask

  task automatic step(input bit s, input bit p, input bit os, input int d, input int l);
    start    = s;
    stop     = p;
    one_shot = os;
    dwell    = d[DW-1:0];
    last_idx = l[N-1:0];
    @(posedge clk);
    #1;
    model_edge(s, p, os, d, l);
    start = 1'b0;
    stop  = 1'b0;
    check_outputs();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic run_until_idx(input int idx, input string tag);
    int guard = 0;
    while (!(m_active && exp_idx() == idx && pos_in_period() % slot_len() == 0) && guard < 200) begin
      step(0, 0, 0, 0, 0);
      guard++;
    end
    if (guard >= 200) check(tag, 32'(guard), 32'd0);
  endtask

  initial begin
    bit s, p, os;
    int d, l;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_w", 32'(w), 32'd0);
    check("rst_en", 32'(en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    #2 rst_n = 1'b1;
    idle_steps(2);

    // Continuous, dwell 2, full range: covers the wrap pulse
    step(1, 0, 0, 2, 7);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    idle_steps(1);

    // One-shot, dwell 0 treated as 1
    step(1, 0, 1, 0, 3);
    idle_steps(7);

    // Stop mid-scan at w=5
    step(1, 0, 0, 4, 7);
    run_until_idx(5, "to_w5");
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    idle_steps(2);

    // start+stop together in IDLE, then start while busy
    step(1, 1, 0, 1, 7);
    idle_steps(1);
    step(1, 0, 0, 1, 4);
    run_until_idx(2, "to_w2");
    step(1, 0, 1, 3, 1);
    idle_steps(10);
    step(0, 1, 0, 0, 0);

    // Dwell 1, last 2, continuous; last_idx=0 in both modes
    step(1, 0, 0, 1, 2);
    idle_steps(9);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 3, 0);
    idle_steps(9);
    step(0, 1, 0, 0, 0);
    step(1, 0, 1, 3, 0);
    idle_steps(6);

    // Asynchronous reset mid-scan at w=4
    step(1, 0, 0, 4, 7);
    run_until_idx(4, "to_w4");
    #2 rst_n = 1'b0;
    #1;
    check("arst_w", 32'(w), 32'd0);
    check("arst_en", 32'(en), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    m_active = 0;
    m_done   = 0;
    @(posedge clk);
    #1;
    check_outputs();
    #2 rst_n = 1'b1;
    idle_steps(2);

    // Randomized traffic; config inputs change freely to exercise capture-on-start
    for (int i = 0; i < 4000; i++) begin
      s  = ($urandom_range(0, 5) == 0);
      p  = ($urandom_range(0, 149) == 0);
      os = $urandom_range(0, 1);
      d  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 12));
      l  = $urandom_range(0, 7);
      step(s, p, os, d, l);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
